// File: rtl/shift_onehot_encode_seq.sv
// shift_onehot_encode_seq
// Sequential one-hot encoder. Each accepted word is shifted right one bit per
// cycle. The block reports the index of the lowest set bit, whether the word
// was all zeros, and whether it had more than one set bit.
module shift_onehot_encode_seq #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter is one bit wider than the index so that it can count
    // WIDTH edges without wrapping when the top bit is the one that is set.
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(WIDTH - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [IDX_W:0]   cnt_q,       cnt_d;
    logic             found_q,     found_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             multi_q,     multi_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;
    logic             out_zero_q,  out_zero_d;
    logic             out_multi_q, out_multi_d;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_idx   = out_idx_q;
    assign out_zero  = out_zero_q;
    assign out_multi = out_multi_q;

    // Next-state logic: accept a word, scan it one bit per edge, then hold the result.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        idx_d       = idx_q;
        multi_d     = multi_q;
        out_idx_d   = out_idx_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    idx_d   = '0;
                    multi_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sr_q[0]) begin
                    if (!found_q) begin
                        idx_d   = cnt_q[IDX_W-1:0];
                        found_d = 1'b1;
                    end else begin
                        multi_d = 1'b1;
                    end
                end
                sr_d  = sr_q >> 1;
                cnt_d = cnt_q + CNT_ONE;
                // The last scan edge also examines the top bit, so the result
                // registers take the values updated on this same edge.
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    out_idx_d   = idx_d;
                    out_zero_d  = !found_d;
                    out_multi_d = multi_d;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            multi_q     <= 1'b0;
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            multi_q     <= multi_d;
            out_idx_q   <= out_idx_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
        end
    end

endmodule

// File: tb/tb_shift_onehot_encode_seq.sv
// tb_shift_onehot_encode_seq
// Directed test of the sequential one-hot encoder with hand-computed results.
module tb_shift_onehot_encode_seq;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_zero;
    logic             out_multi;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned cyc      = 0;

    shift_onehot_encode_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_multi (out_multi)
    );

    always #5 clk = ~clk;

    // Free-running edge counter for throughput measurement.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid with a bound; returns the number of edges waited.
    task automatic wait_valid(output int unsigned n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // One full transaction; the result is held hold_cycles edges before out_ready.
    task automatic run_word(input logic [WIDTH-1:0] data, input int unsigned exp_idx,
                            input logic exp_zero, input logic exp_multi,
                            input int unsigned hold_cycles);
        int unsigned n;
        check("ready_idle", {31'd0, in_ready}, 32'd1);
        in_data  = data;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        check("ready_busy", {31'd0, in_ready}, 32'd0);
        check("valid_busy", {31'd0, out_valid}, 32'd0);
        wait_valid(n);
        check("latency", n, 32'd8);
        check("idx", {29'd0, out_idx}, exp_idx);
        check("zero", {31'd0, out_zero}, {31'd0, exp_zero});
        check("multi", {31'd0, out_multi}, {31'd0, exp_multi});
        for (int i = 0; i < int'(hold_cycles); i++) begin
            step();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_idx", {29'd0, out_idx}, exp_idx);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drop", {31'd0, out_valid}, 32'd0);
        check("ready_back", {31'd0, in_ready}, 32'd1);
        check("idx_kept", {29'd0, out_idx}, exp_idx);
    endtask

    initial begin
        int unsigned n;
        int unsigned acc_cyc;
        int unsigned prev_acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_idx", {29'd0, out_idx}, 32'd0);
        check("rst_zero", {31'd0, out_zero}, 32'd0);
        check("rst_multi", {31'd0, out_multi}, 32'd0);

        // out_ready while idle does nothing.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_oready", {31'd0, in_ready}, 32'd1);

        run_word(8'h10, 4, 1'b0, 1'b0, 0);
        run_word(8'h00, 0, 1'b1, 1'b0, 0);
        run_word(8'h28, 3, 1'b0, 1'b1, 0);
        run_word(8'hFF, 0, 1'b0, 1'b1, 0);
        run_word(8'h80, 7, 1'b0, 1'b0, 5);
        run_word(8'h06, 1, 1'b0, 1'b1, 1);

        // Reset on the third scan edge discards the word and clears outputs.
        in_data  = 8'h04;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_idx", {29'd0, out_idx}, 32'd0);
        check("mid_rst_multi", {31'd0, out_multi}, 32'd0);
        check("mid_rst_zero", {31'd0, out_zero}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mid_rst_novalid", {31'd0, out_valid}, 32'd0);
        end
        run_word(8'h01, 0, 1'b0, 1'b0, 0);

        // Reset and in_valid together: the word is not accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid", {31'd0, in_ready}, 32'd1);

        // Back-to-back sweep with both handshakes tied high.
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int k = 0; k < WIDTH; k++) begin
            check("sweep_ready", {31'd0, in_ready}, 32'd1);
            in_data  = WIDTH'(1) << k;
            in_valid = 1'b1;
            step();
            acc_cyc = cyc;
            if (k > 0) check("sweep_period", acc_cyc - prev_acc, 32'd10);
            prev_acc = acc_cyc;
            in_data  = WIDTH'($urandom);
            wait_valid(n);
            check("sweep_latency", n, 32'd8);
            check("sweep_idx", {29'd0, out_idx}, k);
            check("sweep_zero", {31'd0, out_zero}, 32'd0);
            check("sweep_multi", {31'd0, out_multi}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_onehot_encode_seq.md
Name: shift_onehot_encode_seq

Overview:
Sequential inverse of the dynamic-index one-hot decode (out[idx] = 1). It accepts a WIDTH-bit word over a valid/ready handshake and scans it with a one-bit-per-cycle logical right shift. It returns the index of the lowest set bit, plus flags for an all-zero word and for more than one set bit. It is the encode end of the shift/index test pair, used for round-trip equivalence checks against the one-hot decode.

Parameters:
WIDTH, 8, data word width; must be >= 2 (non-power-of-two allowed)
IDX_W, $clog2(WIDTH), width of the index output (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word offered
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  WIDTH  word to encode; sampled only on the accepting edge
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_idx  output  IDX_W  index of lowest set bit of the accepted word
out_zero  output  1  accepted word was all zeros
out_multi  output  1  accepted word had two or more set bits

Behaviour:
- Reset (rst high at an edge, any state): state = IDLE, out_valid = 0, out_idx = 0, out_zero = 0, out_multi = 0. Shift register, counter and found flag cleared. Any in-flight scan is discarded; no partial result is ever presented.
- in_ready = (state == IDLE), decoded from registered state. out_valid = (state == DONE).
- States:
  - IDLE: on the edge with in_valid && in_ready, load sr <= in_data, cnt <= 0, found <= 0, idx <= 0, multi <= 0, then go to SCAN. in_valid low: stay.
  - SCAN: each edge examines sr[0]:
    - sr[0] = 1 and !found: idx <= cnt[IDX_W-1:0], found <= 1.
    - sr[0] = 1 and found: multi <= 1.
    - Every SCAN edge: sr <= sr >> 1 (logical, zero fill); cnt <= cnt + 1.
    - cnt is IDX_W+1 bits. On the edge where cnt == WIDTH-1, go to DONE and register the outputs: out_idx = final idx, out_zero = !found_final, out_multi = final multi.
    - There is no early exit; SCAN always lasts exactly WIDTH edges.
  - DONE: hold out_idx, out_zero and out_multi stable. On the edge with out_ready high, go to IDLE. Outputs keep their values (not cleared) until the next DONE entry or reset.
- Latency: accepting edge E0; SCAN edges E1..E_WIDTH; out_valid high from the cycle after E_WIDTH. That is WIDTH edges after acceptance (8 for the default).
- Throughput: with in_valid and out_ready tied high, one word per WIDTH+2 cycles. There is no accept in the DONE/handshake cycle and no overlap.
- All-zero word: out_zero = 1, out_idx = 0, out_multi = 0.
- Multiple set bits: out_multi = 1, out_idx = lowest set bit.
- Bit WIDTH-1 alone: out_idx = WIDTH-1, with no counter wrap (cnt is IDX_W+1 bits).
- in_data changes after the accepting edge have no effect. in_valid while busy is ignored (in_ready low); the producer must hold the word.
- out_ready while out_valid is low has no effect.
- rst and in_valid in the same cycle: reset wins and the word is not accepted.

Test Plan:
- Reset, then in_data=8'h10 with in_valid for 1 cycle -> in_ready drops the next cycle; 8 edges later out_valid=1, out_idx=4, out_zero=0, out_multi=0.
- in_data=8'h00 -> out_valid after 8 edges with out_idx=0, out_zero=1, out_multi=0.
- in_data=8'h28 -> out_idx=3, out_multi=1, out_zero=0; in_data=8'hFF -> out_idx=0, out_multi=1.
- in_data=8'h80, out_ready held low 5 cycles after out_valid -> out_idx=7 stable and in_ready=0 throughout; out_ready=1 for one edge -> out_valid=0 and in_ready=1 the next cycle.
- rst pulsed on the 3rd SCAN edge of in_data=8'h04 -> next cycle out_valid=0, in_ready=1, all outputs 0; then in_data=8'h01 -> out_idx=0.
- Sweep in_data = 1<<k for k=0..7 with in_valid and out_ready tied high -> results out_idx=k in order, one every 10 cycles, never out_zero or out_multi.
